// File: rtl/rep_code_pkg.sv
// Shared constants and types for the repetition-code transmitter and its matching receiver.
package rep_code_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_REP    = 3;
    localparam int unsigned FRAME_LEN  = DEF_DATA_W * DEF_REP;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Counter width for a 0..range-1 count; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/rep_beat_counter.sv
// Beat position within a frame: repetition index inside a bit, and bit index inside the word.
module rep_beat_counter
    import rep_code_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned REP    = DEF_REP
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    output logic [cnt_w(REP)-1:0]       rep_cnt,
    output logic [cnt_w(DATA_W)-1:0]    bit_cnt,
    output logic                        rep_last_c,
    output logic                        last_c
);

    localparam int unsigned REP_W = cnt_w(REP);
    localparam int unsigned BIT_W = cnt_w(DATA_W);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             bit_last_c;

    assign rep_last_c = (rep_cnt_q == REP_W'(REP - 1));
    assign bit_last_c = (bit_cnt_q == BIT_W'(DATA_W - 1));
    assign last_c     = rep_last_c && bit_last_c;
    assign rep_cnt    = rep_cnt_q;
    assign bit_cnt    = bit_cnt_q;

    // Both counters wrap to zero on the final beat, leaving them ready for the next frame.
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        bit_cnt_d = bit_cnt_q;
        if (en) begin
            if (rep_last_c) begin
                rep_cnt_d = '0;
                bit_cnt_d = bit_last_c ? '0 : bit_cnt_q + BIT_W'(1);
            end else begin
                rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/rep_encoder_tx.sv
// Repetition-code serializer: sends each data bit LSB first, REP beats per bit, under ready/valid flow control.
module rep_encoder_tx
    import rep_code_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned REP    = DEF_REP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              out_valid,
    output logic              tx_bit,
    output logic              tx_sof,
    output logic              busy
);

    localparam int unsigned REP_W = cnt_w(REP);
    localparam int unsigned BIT_W = cnt_w(DATA_W);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [REP_W-1:0]  rep_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic              rep_last_c;
    logic              last_c;
    logic              beat_acc_c;
    logic              accept_c;

    assign busy       = (state_q == SEND);
    assign out_valid  = busy;
    assign beat_acc_c = out_valid && out_ready;
    assign tx_sof     = busy && (rep_cnt == '0) && (bit_cnt == '0);
    assign tx_bit     = busy && shreg_q[0];

    rep_beat_counter #(
        .DATA_W (DATA_W),
        .REP    (REP)
    ) u_beat_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (beat_acc_c),
        .rep_cnt    (rep_cnt),
        .bit_cnt    (bit_cnt),
        .rep_last_c (rep_last_c),
        .last_c     (last_c)
    );

    // A new word may only land when the shifter is free by the next edge: idle, or on an accepted final beat.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
            SEND:    in_ready = last_c && out_ready;
            default: in_ready = 1'b0;
        endcase
        accept_c = in_valid && in_ready;
        if (beat_acc_c && rep_last_c) begin
            shreg_d = shreg_q >> 1;
        end
        if (accept_c) begin
            shreg_d = in_data;
            state_d = SEND;
        end else if (beat_acc_c && last_c) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: tb/tb_rep_encoder_tx.sv
// Self-checking bench for rep_encoder_tx: beat-queue reference model, majority-vote loopback and directed frames.
module tb_rep_encoder_tx;

    localparam int DW = 8;
    localparam int RP = 3;
    localparam int FL = DW * RP;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_ready;
    logic          out_valid;
    logic          tx_bit;
    logic          tx_sof;
    logic          busy;

    rep_encoder_tx #(.DATA_W(DW), .REP(RP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .tx_bit    (tx_bit),
        .tx_sof    (tx_sof),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Model: queue of beats still owed downstream, each {sof, bit}.
    logic [1:0]    mq[$];
    logic [DW-1:0] sent_q[$];
    bit            m_acc = 1'b0;
    bit            m_rdy;
    int            or_mode = 0;
    int            or_idx  = 0;

    // Receiver / capture state
    int            rx_cnt, rx_ones;
    logic [DW-1:0] rx_word;
    bit            rx_act = 1'b0;
    bit            cap_en = 1'b0;
    logic [47:0]   cap, cap_sof;
    int            cap_n = 0;
    int            sof_seen = 0;
    int            gap = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            sent_q.delete();
            m_acc = 1'b0;
        end else begin
            m_rdy = (mq.size() == 0) || (mq.size() == 1 && out_ready);
            m_acc = in_valid && m_rdy;
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (m_acc) begin
                for (int i = 0; i < FL; i++) mq.push_back({i == 0, in_data[i / RP]});
                sent_q.push_back(in_data);
            end
        end
    end

    // Compare every cycle, then run the majority receiver on beats that will be accepted.
    always @(negedge clk) begin
        logic ev, eb, es, er;
        ev = (mq.size() > 0);
        eb = ev ? mq[0][0] : 1'b0;
        es = ev ? mq[0][1] : 1'b0;
        er = (mq.size() == 0) || (mq.size() == 1 && out_ready);
        chk("out_valid", out_valid, ev);
        chk("busy", busy, ev);
        chk("tx_bit", tx_bit, eb);
        chk("tx_sof", tx_sof, es);
        chk("in_ready", in_ready, er);
        if (!rst_n) begin
            rx_act = 1'b0;
        end else begin
            if (cap_en && cap_n > 0 && cap_n < 48 && !out_valid) gap++;
            if (out_valid && out_ready) begin
                if (tx_sof) begin
                    rx_act = 1'b1; rx_cnt = 0; rx_ones = 0; rx_word = '0; sof_seen++;
                end
                if (rx_act) begin
                    rx_ones += int'(tx_bit);
                    rx_cnt++;
                    if (rx_cnt % RP == 0) begin
                        rx_word[rx_cnt / RP - 1] = (rx_ones > RP / 2);
                        rx_ones = 0;
                    end
                    if (rx_cnt == FL) begin
                        rx_act = 1'b0;
                        if (sent_q.size() == 0) chk("rx_extra_frame", 1, 0);
                        else chk("loopback_word", rx_word, sent_q.pop_front());
                    end
                end
                if (cap_en && cap_n < 48) begin
                    cap[cap_n] = tx_bit;
                    cap_sof[cap_n] = tx_sof;
                    cap_n++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       begin out_ready = (or_idx % 3 == 0); or_idx++; end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send(input logic [DW-1:0] w, input bit hold, output int n);
        n = 0;
        in_valid = 1'b1;
        in_data  = w;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!m_acc && n < 500);
        if (!m_acc) chk("accept_timeout", 0, 1);
        if (!hold) begin
            in_valid = 1'b0;
            in_data  = DW'($urandom);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (mq.size() != 0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (mq.size() != 0) chk("idle_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic start_cap();
        cap_en = 1'b1; cap_n = 0; cap = '0; cap_sof = '0; sof_seen = 0; gap = 0;
    endtask

    initial begin
        int n;
        logic [DW-1:0] loop_words [5];
        loop_words = '{8'd15, 8'd25, 8'd95, 8'd5, 8'd3};
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_sof", tx_sof, 0);
        chk("rst_tx_bit", tx_bit, 0);
        chk("rst_in_ready", in_ready, 1);
        #14 rst_n = 1'b1;

        // Single frame 0x0F, accepted on the first edge after reset release.
        start_cap();
        send(8'h0F, 1'b0, n);
        chk("first_edge_accept", n, 1);
        wait_idle();
        chk("f0F_beats", cap[23:0], 24'h000FFF);
        chk("f0F_count", cap_n, 24);
        chk("f0F_sof", cap_sof[23:0], 24'h000001);

        // Backpressure 1,0,0 pattern: same beat sequence as without stalls.
        or_mode = 1; or_idx = 0;
        start_cap();
        send(8'h19, 1'b0, n);
        wait_idle();
        chk("f19_stall_beats", cap[23:0], 24'h007E07);
        chk("f19_stall_sof", cap_sof[23:0], 24'h000001);

        // Back-to-back with in_valid held across the final beat.
        or_mode = 0;
        start_cap();
        send(8'h5F, 1'b1, n);
        send(8'h03, 1'b0, n);
        wait_idle();
        chk("b2b_count", cap_n, 48);
        chk("b2b_beats", cap, {24'h00003F, 24'h1C7FFF});
        chk("b2b_sof", cap_sof, 48'h000001_000001);
        chk("b2b_gap", gap, 0);

        // in_valid pulse mid-frame must be ignored.
        start_cap();
        send(8'h05, 1'b0, n);
        repeat (4) @(posedge clk);
        #1 in_valid = 1'b1; in_data = 8'hFF;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_idle();
        chk("ign_sof_count", sof_seen, 1);
        chk("ign_beats", cap[23:0], 24'h0001C7);
        chk("ign_count", cap_n, 24);

        // Reset at beat 10 of 0x03.
        send(8'h03, 1'b0, n);
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tx_sof", tx_sof, 0);
        chk("mid_rst_tx_bit", tx_bit, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        start_cap();
        send(8'h19, 1'b0, n);
        wait_idle();
        chk("post_rst_beats", cap[23:0], 24'h007E07);
        chk("post_rst_count", cap_n, 24);
        chk("post_rst_sof", cap_sof[23:0], 24'h000001);
        cap_en = 1'b0;

        // Loopback through the majority receiver, random backpressure.
        or_mode = 2;
        foreach (loop_words[i]) send(loop_words[i], 1'b0, n);
        wait_idle();
        for (int i = 0; i < 40; i++) begin
            send(DW'($urandom), 1'($urandom_range(0, 1)), n);
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 30)) @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        wait_idle();
        chk("loopback_pending", sent_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rep_encoder_tx.md
REP_ENCODER_TX -- requirements
Module: rep_encoder_tx

Interface
REQ-001 Parameter DATA_W, default 8: width of the input data word, in bits.
REQ-002 Parameter REP, default 3: serial repetitions per data bit; SHALL be odd and at least 3.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1: in_data is valid this cycle.
REQ-006 Port in_data, input, DATA_W: word to transmit.
REQ-007 Port in_ready, output, 1: block accepts in_data this cycle.
REQ-008 Port out_ready, input, 1: downstream majority receiver accepts the current beat.
REQ-009 Port out_valid, output, 1: tx_bit is a valid beat.
REQ-010 Port tx_bit, output, 1: current serial beat.
REQ-011 Port tx_sof, output, 1: marks the first beat of a frame.
REQ-012 Port busy, output, 1: a frame is in progress.

Function
REQ-013 A word SHALL be accepted on a rising edge where in_valid and in_ready are both high.
REQ-014 The state machine SHALL have two states: IDLE and SEND.
REQ-015 IDLE SHALL go to SEND on accept.
REQ-016 SEND SHALL go to IDLE when the final beat is accepted and no new word is accepted on the same edge.
REQ-017 Each frame SHALL be DATA_W*REP beats: each data bit, LSB first, repeated REP consecutive beats.
REQ-018 A beat SHALL advance only on a rising edge where out_valid and out_ready are both high.
REQ-019 While out_ready is low, tx_bit, tx_sof, out_valid and all counters SHALL hold.
REQ-020 Latency: out_valid SHALL go high in the cycle after accept, with tx_sof=1 and tx_bit=in_data[0].
REQ-021 tx_sof SHALL be high only on beat 0 of a frame.
REQ-022 Counters: rep_cnt SHALL count 0..REP-1 and bit_cnt 0..DATA_W-1.
REQ-023 rep_cnt SHALL wrap to 0 and bit_cnt SHALL increment when rep_cnt=REP-1 and the beat is accepted.
REQ-024 Counter widths SHALL be $clog2 of their ranges, with no overflow at the maximum values.
REQ-025 in_ready SHALL be high in IDLE.
REQ-026 In SEND, in_ready SHALL be high only on the final beat (bit_cnt=DATA_W-1, rep_cnt=REP-1) while out_ready=1.
REQ-027 Back-to-back frames: if a word is accepted on the final-beat edge, the next cycle SHALL start the new frame (tx_sof=1) with no idle gap.
REQ-028 in_valid high in SEND outside the final beat SHALL be ignored, and in_data SHALL not be sampled.
REQ-029 busy SHALL equal (state==SEND).
REQ-030 out_valid SHALL equal busy.
REQ-031 tx_bit SHALL be 0 whenever out_valid is low.

Reset
REQ-032 On rst_n low, immediately and regardless of clk, the block SHALL enter IDLE.
REQ-033 During reset, the counters and shift register SHALL clear to 0.
REQ-034 During reset, the outputs SHALL be out_valid=0, tx_bit=0, tx_sof=0, busy=0, in_ready=1.
REQ-035 A reset mid-frame SHALL abandon the frame; no partial beats SHALL be sent after reset release.
REQ-036 The first edge after rst_n rises SHALL be able to accept a word.

Structure
REQ-037 A shared package rep_code_pkg SHALL hold the default DATA_W and REP.
REQ-038 rep_code_pkg SHALL hold the state enum (IDLE, SEND).
REQ-039 rep_code_pkg SHALL hold the frame-length constant DATA_W*REP, for reuse by the majority-vote receiver.
REQ-040 One sub-module, rep_beat_counter (rep_cnt/bit_cnt with enable, wrap and last-beat flag), SHALL be instantiated; the datapath shift register SHALL stay in the top module.

Verification
REQ-041 Single frame: in_data=8'h0F, out_ready=1 -> 24 beats 111 111 111 111 000 000 000 000; tx_sof on beat 0 only; busy drops after beat 23.
REQ-042 Backpressure: in_data=8'h19, out_ready toggled 1,0,0,1,... -> beat sequence identical to the no-stall case; outputs held during stall cycles.
REQ-043 Back-to-back: 8'h5F then 8'h03 with in_valid held -> second tx_sof in the cycle after beat 23 of the first frame; 48 contiguous beats.
REQ-044 Ignored input: in_valid pulse with 8'hFF mid-frame of 8'h05 -> frame 8'h05 unchanged; no second frame starts.
REQ-045 Reset mid-frame: rst_n low at beat 10 of 8'h03 -> outputs at reset values immediately; after release, 8'h19 transmits cleanly from tx_sof.
REQ-046 Loopback: feed beats to a REP-way majority voter and deserializer -> recovered words equal inputs for 15, 25, 95, 5, 3.
